// File: rtl/key_expansion_192.sv
// One registered step of the AES-192 key schedule: six input words become the
// next six expanded-key words. The S-box is computed as GF(2^8) inverse plus affine map.
module key_expansion_192 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [191:0] KeyI,
    input  logic [31:0]  rcon,
    output logic [191:0] KeyF,
    output logic         valid_o
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]  rot;
    logic [31:0]  temp;
    logic [31:0]  n0, n1, n2, n3, n4, n5;
    logic [191:0] next_key;

    always_comb begin
        rot  = {KeyI[23:0], KeyI[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ rcon;
        n0   = KeyI[191:160] ^ temp;
        n1   = KeyI[159:128] ^ n0;
        n2   = KeyI[127:96]  ^ n1;
        n3   = KeyI[95:64]   ^ n2;
        n4   = KeyI[63:32]   ^ n3;
        n5   = KeyI[31:0]    ^ n4;
        next_key = {n0, n1, n2, n3, n4, n5};
    end

    // valid_i is a capture strobe with no backpressure: every cycle it is high the
    // inputs are consumed, and valid_o marks the cycle whose KeyF holds that result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            KeyF    <= 192'h0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) KeyF <= next_key;
        end
    end

endmodule

// File: tb/tb_key_expansion_192.sv
// Bench for key_expansion_192: FIPS-197 vectors, hold, chained schedule, async reset
// and a random regression against a table-driven key-schedule model.
module tb_key_expansion_192;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [191:0] key_i;
    logic [31:0]  rcon_i;
    logic [191:0] key_f;
    logic         valid_o;

    int total = 0;
    int bad   = 0;

    logic [192:0] exp_q[$];
    logic [191:0] model_key;

    localparam logic [191:0] C2_KEY  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] C2_STEP = 192'h5846f2f95c43f4fe544afef55847f0fa4856e2e95c43f4fe;

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    key_expansion_192 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .KeyI    (key_i),
        .rcon    (rcon_i),
        .KeyF    (key_f),
        .valid_o (valid_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_flat[2047 - 8*x -: 8];
    endfunction

    // Key schedule rule: each new word is the previous new word XOR the word six back,
    // the first one seeded by SubWord(RotWord(last word)) ^ rcon.
    function automatic logic [191:0] ref_step(input logic [191:0] k, input logic [31:0] rc);
        logic [31:0]  w[6];
        logic [31:0]  prev;
        logic [31:0]  t;
        logic [191:0] out;
        for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
        t = {sb(w[5][23:16]), sb(w[5][15:8]), sb(w[5][7:0]), sb(w[5][31:24])} ^ rc;
        prev = t;
        out = '0;
        for (int i = 0; i < 6; i++) begin
            prev = w[i] ^ prev;
            out[191 - 32*i -: 32] = prev;
        end
        return out;
    endfunction

    task automatic check(input string tag, input logic [191:0] k_exp, input logic v_exp);
        total++;
        assert (key_f === k_exp) else begin
            bad++;
            $error("FAIL %s key_f got=%h exp=%h", tag, key_f, k_exp);
        end
        total++;
        assert (valid_o === v_exp) else begin
            bad++;
            $error("FAIL %s valid_o got=%b exp=%b", tag, valid_o, v_exp);
        end
    endtask

    // driver: called at a falling edge, applies one cycle and scoreboards the result
    task automatic drive_cycle(input logic v, input logic [191:0] k, input logic [31:0] r,
                               input string tag);
        logic [192:0] e;
        valid_i = v;
        key_i   = k;
        rcon_i  = r;
        if (v) model_key = ref_step(k, r);
        exp_q.push_back({v, model_key});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, e[191:0], e[192]);
    endtask

    function automatic logic [191:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [191:0] cur;
        logic [31:0]  rc;
        logic         v;

        rst_n = 1'b0; valid_i = 1'b0; key_i = '0; rcon_i = '0; model_key = '0;
        #2;
        check("reset", 192'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive_cycle(1'b1, C2_KEY, 32'h01000000, "c2_step1");
        total++;
        assert (key_f === C2_STEP) else begin
            bad++;
            $error("FAIL c2_golden key_f got=%h exp=%h", key_f, C2_STEP);
        end

        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, rand_key(), $urandom, "hold");
            total++;
            assert (key_f === C2_STEP) else begin
                bad++;
                $error("FAIL hold_golden key_f got=%h exp=%h", key_f, C2_STEP);
            end
        end

        drive_cycle(1'b1, 192'h0, 32'h01000000, "zero_key");
        total++;
        assert (key_f === {6{32'h62636363}}) else begin
            bad++;
            $error("FAIL zero_golden key_f got=%h exp=%h", key_f, {6{32'h62636363}});
        end

        drive_cycle(1'b1, C2_KEY, 32'h0, "rcon_zero");
        drive_cycle(1'b1, C2_KEY, 32'hdeadbeef, "rcon_odd");

        // chained schedule, back-to-back
        cur = C2_KEY;
        for (int i = 0; i < 8; i++) begin
            rc = 32'h01000000 << i;
            drive_cycle(1'b1, cur, rc, "chain");
            if (i == 1) begin
                total++;
                assert (key_f[191:64] === 128'h40f949b31cbabd4d48f043b810b7b342) else begin
                    bad++;
                    $error("FAIL chain_w12 key_f got=%h exp=%h", key_f[191:64],
                           128'h40f949b31cbabd4d48f043b810b7b342);
                end
            end
            cur = model_key;
        end

        // asynchronous reset between edges while valid_o is high
        #2;
        rst_n = 1'b0;
        #1;
        model_key = '0;
        check("async_rst", 192'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", 192'h0, 1'b0);
        rst_n = 1'b1;
        drive_cycle(1'b1, C2_KEY, 32'h01000000, "post_rst");

        for (int i = 0; i < 10000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 1) == 0) ? (32'h01000000 << $urandom_range(0, 7)) : $urandom;
            drive_cycle(v, rand_key(), rc, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_expansion_192.md
# key_expansion_192

Registered single-step AES-192 key-schedule block. Takes six 32-bit round-key words and a round constant, and produces the next six words of the expanded key schedule one clock later. Instances are chained by the key-expansion/cipher control logic, which supplies rcon = 01, 02, 04, 08, 10, 20, 40, 80 (in the top byte) per step. The S-box for SubWord is internal to the block.

## Interface
- No parameters.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset. Asynchronous and active-low.
- valid_i  input  1  KeyI/rcon valid this cycle; capture strobe.
- KeyI  input  192  current six words, w0 = KeyI[191:160] … w5 = KeyI[31:0].
- rcon  input  32  round constant word; only [31:24] is nonzero in normal use, but all 32 bits are XORed.
- KeyF  output  192  next six words, n0 = KeyF[191:160] … n5 = KeyF[31:0]. Registered.
- valid_o  output  1  KeyF holds a newly computed result; registered copy of valid_i.

## Operation
- RotWord: r = {w5[23:0], w5[31:24]}, a cyclic left rotate by one byte.
- SubWord: apply the AES forward S-box (FIPS-197 Fig. 7) to each of the 4 bytes of r independently.
  - Implement it as 4 combinational S-box instances (256-entry case table) or as GF(2^8) inverse plus affine transform.
- temp = SubWord(RotWord(w5)) ^ rcon.
- n0 = w0 ^ temp.
- n1 = w1 ^ n0, n2 = w2 ^ n1, n3 = w3 ^ n2, n4 = w4 ^ n3, n5 = w5 ^ n4.
- All arithmetic is bitwise XOR; no carries, no width growth.
- No state machine. The only state is the KeyF and valid_o registers.
- When valid_i = 1, the combinational result is loaded into KeyF.
- When valid_i = 0, KeyF holds its previous value.
- valid_o <= valid_i every cycle.
- rcon is not checked. Any 32-bit value is applied as given, including 0 and non-standard constants.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge k with valid_i = 1 appear on KeyF after that edge, with valid_o = 1 for that cycle.
- Throughput is one expansion per cycle. Back-to-back valid_i is fully supported, with no bubbles.
- Reset: while rst_n = 0, KeyF = 192'h0 and valid_o = 0 immediately, independent of clk.
- Deassertion of rst_n takes effect at the next rising edge, which samples normally.
- Reset mid-stream: any result in flight is discarded. The first output after reset comes from the first valid_i sampled after deassertion.
- Input changes while valid_i = 0 have no effect on outputs.
- The combinational path from KeyI[31:0] through the S-box and a 6-deep XOR chain to the register must close at the target clock; no internal pipelining.

## Test plan
- FIPS-197 C.2 first step:
  - Stimulus: KeyI = 000102030405060708090a0b0c0d0e0f1011121314151617, rcon = 01000000, valid_i = 1.
  - Required: one cycle later KeyF = 5846f2f95c43f4fe544afef55847f0fa4856e2e95c43f4fe and valid_o = 1.
- All-zero key:
  - Stimulus: KeyI = 0, rcon = 01000000.
  - Required: KeyF = 62636363 repeated six times.
- Hold behaviour:
  - Stimulus: apply the C.2 vector, then drop valid_i and drive KeyI = random.
  - Required: KeyF stays 5846f2f9…5c43f4fe and valid_o = 0.
- Chained schedule:
  - Stimulus: feed KeyF back to KeyI with rcon = 01, 02, … 80 (top byte), once per cycle with valid_i = 1.
  - Required: every output matches the FIPS-197 C.2 AES-192 schedule. The second step yields words w12..w17 = 40f949b3 1cbabd4d 48f043b8 10b7b342 …, with w16..w17 taken from the golden model.
- Asynchronous reset mid-stream:
  - Stimulus: assert rst_n = 0 between clock edges while valid_o = 1.
  - Required: KeyF = 0 and valid_o = 0 immediately.
  - After release, a new vector produces the correct result after 1 cycle.
- Random regression:
  - Stimulus: 10k random KeyI/rcon with random valid_i.
  - Required: KeyF and valid_o match a software reference model cycle-by-cycle.
